// File: rtl/chunked_addsub_pkg.sv
// Shared types and configuration checks for the chunk-serial adder/subtractor.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The operand must split into a whole number of equal chunks.
  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk > 0) && (width > 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk.sv
// One CHUNK-bit ripple slice; the top reuses a single instance every RUN cycle.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first,
// with results and flags registered on completion.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             sign,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunked_addsub: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             cin_q, cin_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sign_q, sign_d, carry_q, carry_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;

  logic [CHUNK-1:0]       sum_sl;
  logic                   cout_sl, msb_cin;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  // Operands shift right each cycle, so the live slice is always at the bottom.
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (cin_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  // Each new slice enters at the top of the partial result and shifts down.
  assign res_cat  = {sum_sl, res_q};
  assign res_next = res_cat[WIDTH+CHUNK-1:CHUNK];
  assign msb_cin  = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum_sl[CHUNK-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cin_d   = cin_q;
    out_d   = out_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = sub ? ~B : B;
          cin_d   = sub;
          idx_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = res_next;
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        cin_d = cout_sl;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          out_d   = res_next;
          sign_d  = res_next[WIDTH-1];
          zero_d  = (res_next == '0);
          carry_d = cout_sl;
          ovf_d   = msb_cin ^ cout_sl;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign sign     = sign_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule
